audio_i2s_stream_tx: RTL

- Sink end of the audio sample stream driven by rtl_top.
- Accepts audio_data/audio_id/audio_valid and returns audio_ready.
- Buffers the samples in a small FIFO and serialises them as standard I2S (BCLK, LRCK, SDATA) to the codec.
- Runs entirely in the audio clock domain (24.576 MHz nominal).

---
 rtl/audio_i2s_stream_tx_if.sv | 13 +
 rtl/audio_i2s_stream_tx.sv | 105 ++++++++++
 2 files changed

// File: rtl/audio_i2s_stream_tx_if.sv
// Sample stream from the upstream producer into the I2S transmitter.
// The producer holds valid; the transmitter returns ready.
interface audio_i2s_stream_tx_if #(
  parameter int unsigned SAMPLE_BITS = 24
);
  logic [SAMPLE_BITS-1:0] audio_data;
  logic                   audio_id;
  logic                   audio_valid;
  logic                   audio_ready;

  modport master (output audio_data, audio_id, audio_valid, input audio_ready);
  modport slave  (input audio_data, audio_id, audio_valid, output audio_ready);
endinterface

// File: rtl/audio_i2s_stream_tx.sv
// Buffers {id, sample} pairs in a small FIFO and serialises them as I2S
// (BCLK, LRCK, SDATA), all in the audio clock domain.
module audio_i2s_stream_tx #(
  parameter int unsigned SAMPLE_BITS     = 24,
  parameter int unsigned SLOT_BITS       = 32,
  parameter int unsigned BCLK_DIV        = 8,
  parameter int unsigned FIFO_DEPTH_BITS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  audio_i2s_stream_tx_if.slave        audio,
  output logic                        i2s_bclk,
  output logic                        i2s_lrck,
  output logic                        i2s_sdata,
  output logic [15:0]                 underrun_count
);

  localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_BITS;
  localparam int unsigned DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(2 * SLOT_BITS);
  localparam int unsigned OCC_W = FIFO_DEPTH_BITS + 1;

  logic [DIV_W-1:0]           div_cnt;
  logic [BIT_W-1:0]           bit_cnt;
  logic [BIT_W-1:0]           bit_cnt_next;
  logic                       fe;
  logic                       load;
  logic                       load_right;

  logic [SAMPLE_BITS:0]       mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
  logic [OCC_W-1:0]           occ;
  logic [OCC_W-1:0]           occ_next;
  logic                       push;
  logic                       pop;
  logic                       empty;
  logic                       head_id;
  logic [SAMPLE_BITS-1:0]     head_data;
  logic [SAMPLE_BITS-1:0]     shreg;

  assign fe           = (div_cnt == DIV_W'(BCLK_DIV - 1));
  assign bit_cnt_next = (bit_cnt == BIT_W'(2 * SLOT_BITS - 1)) ? '0 : bit_cnt + BIT_W'(1);
  // Slot data starts one BCLK after the LRCK transition (I2S delay bit).
  assign load         = fe && ((bit_cnt_next == BIT_W'(1)) ||
                               (bit_cnt_next == BIT_W'(SLOT_BITS + 1)));
  assign load_right   = (bit_cnt_next >= BIT_W'(SLOT_BITS));

  assign empty                 = (occ == '0);
  assign {head_id, head_data}  = mem[rd_ptr];
  assign push                  = audio.audio_valid && audio.audio_ready;
  assign pop                   = load && !empty;
  assign occ_next              = occ + OCC_W'(push) - OCC_W'(pop);

  assign i2s_sdata = shreg[SAMPLE_BITS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      i2s_bclk <= 1'b0;
      i2s_lrck <= 1'b0;
    end else begin
      div_cnt  <= fe ? '0 : div_cnt + DIV_W'(1);
      i2s_bclk <= (div_cnt >= DIV_W'(BCLK_DIV / 2));
      if (fe) begin
        bit_cnt  <= bit_cnt_next;
        i2s_lrck <= (bit_cnt_next >= BIT_W'(SLOT_BITS));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {audio.audio_id, audio.audio_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      occ               <= '0;
      audio.audio_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(1);
      occ               <= occ_next;
      audio.audio_ready <= (occ_next < OCC_W'(DEPTH));
    end
  end

  // A head entry for the wrong channel is still popped so order resyncs;
  // its slot goes out as silence without counting an underrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg          <= '0;
      underrun_count <= '0;
    end else if (load) begin
      shreg <= (!empty && (head_id == load_right)) ? head_data : '0;
      if (empty && (underrun_count != '1)) underrun_count <= underrun_count + 16'd1;
    end else if (fe) begin
      shreg <= shreg << 1;
    end
  end

endmodule
